// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped BHT/BTB branch predictor with one-cycle flush/redirect recovery.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module branch_predictor_ctrl #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_CNT    = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            id_valid_i,
  input  logic            id_stall_i,
  input  logic            id_Branch_i,
  input  logic            BranchTaken_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_target_i,
  input  logic            id_pred_taken_i,
  input  logic [XLEN-1:0] id_pred_target_i,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bpState_e;

  bpState_e stateQ, stateD;

  logic [BHT_ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]       tagQ    [BHT_ENTRIES];
  logic [XLEN-3:0]        targetQ [BHT_ENTRIES];
  logic [1:0]             cntQ    [BHT_ENTRIES];
  logic [XLEN-1:0]        redirectQ;

  logic [IDX_W-1:0] ifIdx, idIdx;
  logic [TAG_W-1:0] ifTag, idTag;
  logic             ifHit, idHit;
  logic             resolveEv, mispredict;
  logic [1:0]       cntNext;

  // Fetch-side lookup: reads the table as it stands, no bypass from ID.
  assign ifIdx = if_pc_i[IDX_W+1:2];
  assign ifTag = if_pc_i[XLEN-1:IDX_W+2];
  assign ifHit = validQ[ifIdx] && (tagQ[ifIdx] == ifTag);

  assign pred_taken_o  = ifHit && cntQ[ifIdx][1];
  assign pred_target_o = ifHit ? {targetQ[ifIdx], 2'b00} : (if_pc_i + XLEN'(4));

  assign idIdx = id_pc_i[IDX_W+1:2];
  assign idTag = id_pc_i[XLEN-1:IDX_W+2];
  assign idHit = validQ[idIdx] && (tagQ[idIdx] == idTag);

  // Anything presented to ID while flushing is wrong-path and is ignored.
  assign resolveEv  = id_valid_i && !id_stall_i && id_Branch_i && !flush_o;
  assign mispredict = (id_pred_taken_i != BranchTaken_i) ||
                      (BranchTaken_i && id_pred_taken_i && (id_pred_target_i != id_target_i));

  always_comb begin
    cntNext = cntQ[idIdx];
    if (BranchTaken_i) begin
      if (!idHit)                    cntNext = 2'b10;
      else if (cntQ[idIdx] != 2'b11) cntNext = cntQ[idIdx] + 2'b01;
    end else if (cntQ[idIdx] != 2'b00) begin
      cntNext = cntQ[idIdx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validQ <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) cntQ[i] <= INIT_CNT;
    end else if (resolveEv) begin
      cntQ[idIdx] <= cntNext;
      if (BranchTaken_i) validQ[idIdx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (resolveEv && BranchTaken_i) begin
      tagQ[idIdx]    <= idTag;
      targetQ[idIdx] <= id_target_i[XLEN-1:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stateQ <= RUN;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      RUN:     if (resolveEv && mispredict) stateD = RECOVER;
      RECOVER: stateD = RUN;
      default: stateD = RUN;
    endcase
  end

  always_comb begin
    flush_o       = (stateQ == RECOVER);
    redirect_pc_o = redirectQ;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirectQ <= '0;
    end else if ((stateQ == RUN) && resolveEv && mispredict) begin
      redirectQ <= BranchTaken_i ? id_target_i : (id_pc_i + XLEN'(4));
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branchCntQ, mispredCntQ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branchCntQ  <= '0;
      mispredCntQ <= '0;
    end else if (resolveEv) begin
      if (branchCntQ != 32'hFFFF_FFFF) branchCntQ <= branchCntQ + 32'd1;
      if (mispredict && (mispredCntQ != 32'hFFFF_FFFF)) mispredCntQ <= mispredCntQ + 32'd1;
    end
  end

  assign branch_cnt_o  = branchCntQ;
  assign mispred_cnt_o = mispredCntQ;
`else
  assign branch_cnt_o  = 32'h0;
  assign mispred_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: flush/redirect scoreboard plus lookup checks.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifPc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        idValid, idStall, idBranch, branchTaken, idPredTaken;
  logic [31:0] idPc, idTarget, idPredTarget;
  logic        flush;
  logic [31:0] redirectPc, branchCnt, mispredCnt;

  logic [32:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          expBranch = 0;
  int          expMispred = 0;
  logic        inRecover = 1'b0;

  branch_predictor_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_pc_i          (ifPc),
    .pred_taken_o     (predTaken),
    .pred_target_o    (predTarget),
    .id_valid_i       (idValid),
    .id_stall_i       (idStall),
    .id_Branch_i      (idBranch),
    .BranchTaken_i    (branchTaken),
    .id_pc_i          (idPc),
    .id_target_i      (idTarget),
    .id_pred_taken_i  (idPredTaken),
    .id_pred_target_i (idPredTarget),
    .flush_o          (flush),
    .redirect_pc_o    (redirectPc),
    .branch_cnt_o     (branchCnt),
    .mispred_cnt_o    (mispredCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic setId(input logic v, input logic s, input logic b, input logic t,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    idValid = v; idStall = s; idBranch = b; branchTaken = t;
    idPc = pc; idTarget = tgt; idPredTaken = pt; idPredTarget = ptgt;
  endtask

  task automatic setIdle();
    setId(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // One clock: queue the expected flush/redirect, then compare after the edge.
  task automatic step(input logic expFlush, input logic [31:0] expRedir);
    logic [32:0] e;
    if (idValid && !idStall && idBranch && !inRecover && !rst) begin
      expBranch++;
      if (expFlush) expMispred++;
    end
    exp_q.push_back({expFlush, expRedir});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("flush", {31'b0, flush}, {31'b0, e[32]});
    if (e[32]) chk("redirect", redirectPc, e[31:0]);
    inRecover = expFlush;
  endtask

  task automatic look(input logic [31:0] pc, input logic expTaken, input logic [31:0] expTarget);
    ifPc = pc;
    #1;
    chk("predTaken", {31'b0, predTaken}, {31'b0, expTaken});
    chk("predTarget", predTarget, expTarget);
  endtask

  task automatic chkPerf();
`ifdef BP_PERF_CNT_EN
    chk("branchCnt", branchCnt, 32'(expBranch));
    chk("mispredCnt", mispredCnt, 32'(expMispred));
`else
    chk("branchCnt", branchCnt, 32'h0);
    chk("mispredCnt", mispredCnt, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    ifPc = 32'h100;
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstFlush", {31'b0, flush}, 32'h0);
    chk("rstRedirect", redirectPc, 32'h0);
    chk("rstBranchCnt", branchCnt, 32'h0);
    chk("rstMispredCnt", mispredCnt, 32'h0);
    look(32'h100, 1'b0, 32'h104);

    // Cold taken branch allocates with counter 2'b10
    setId(1, 0, 1, 1, 32'h100, 32'h180, 0, 32'h104);
    step(1'b1, 32'h180);
    look(32'h100, 1'b1, 32'h180);
    setIdle();
    step(1'b0, 32'h0);

    // Three correctly predicted taken resolves saturate the counter
    setId(1, 0, 1, 1, 32'h100, 32'h180, 1, 32'h180);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    look(32'h100, 1'b1, 32'h180);

    // Two not-taken resolves: 11 -> 10 -> 01
    setId(1, 0, 1, 0, 32'h100, 32'h180, 1, 32'h180);
    step(1'b1, 32'h104);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b1, 32'h180);
    setId(1, 0, 1, 0, 32'h100, 32'h180, 1, 32'h180);
    step(1'b1, 32'h104);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h180);

    // Wrong-path squash: mismatching branch presented during the flush cycle
    setId(1, 0, 1, 1, 32'h208, 32'h300, 0, 32'h20c);
    step(1'b1, 32'h300);
    setId(1, 0, 1, 1, 32'h100, 32'h400, 0, 32'h104);
    step(1'b0, 32'h0);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h180);
    look(32'h208, 1'b1, 32'h300);

    // Stall hold, then exactly one update on release (01 -> 10)
    setId(1, 1, 1, 1, 32'h100, 32'h180, 0, 32'h104);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h180);
    idStall = 1'b0;
    step(1'b1, 32'h180);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b1, 32'h180);
    setId(1, 0, 1, 0, 32'h100, 32'h180, 1, 32'h180);
    step(1'b1, 32'h104);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h180);

    // Non-branch and invalid ID cycles change nothing
    setId(1, 0, 0, 1, 32'h100, 32'h500, 0, 32'h104);
    step(1'b0, 32'h0);
    setId(0, 0, 1, 1, 32'h100, 32'h500, 0, 32'h104);
    step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h180);

    // Target mismatch with correct direction
    setId(1, 0, 1, 1, 32'h100, 32'h200, 1, 32'h180);
    step(1'b1, 32'h200);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h100, 1'b1, 32'h200);

    // Aliasing: not-taken with another tag only decrements; taken replaces
    setId(1, 0, 1, 0, 32'h1100, 32'h1180, 0, 32'h1104);
    step(1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h200);
    look(32'h1100, 1'b0, 32'h1104);
    setId(1, 0, 1, 1, 32'h1100, 32'h1180, 0, 32'h1104);
    step(1'b1, 32'h1180);
    setIdle();
    step(1'b0, 32'h0);
    look(32'h1100, 1'b1, 32'h1180);
    look(32'h100, 1'b0, 32'h104);

    // PC wrap on fall-through
    setId(1, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h40);
    step(1'b1, 32'h0);
    setIdle();
    step(1'b0, 32'h0);
    look(32'hFFFF_FFFC, 1'b0, 32'h0);

    chkPerf();

    // Reset asserted during the flush cycle
    setId(1, 0, 1, 1, 32'h100, 32'h180, 0, 32'h104);
    step(1'b1, 32'h180);
    rst = 1'b1;
    setIdle();
    step(1'b0, 32'h0);
    rst = 1'b0;
    expBranch = 0;
    expMispred = 0;
    chk("rstRedirect2", redirectPc, 32'h0);
    chkPerf();
    look(32'h100, 1'b0, 32'h104);
    look(32'h208, 1'b0, 32'h20c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
- Fetch-side dynamic branch predictor and misprediction recovery controller for the RV32 pipeline.
- IF looks up a direct-mapped BHT/BTB every cycle to get a predicted direction and target.
- ID resolves the branch with the BranchTaken result from the decode-stage branch determination logic. The block trains its tables from that result and issues a one-cycle flush/redirect on a misprediction.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of BHT/BTB entries; must be a power of 2 and at least 4.
- INIT_CNT, 2'b01, reset value of every 2-bit counter (weakly not-taken).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- if_pc_i  in  XLEN  PC of the instruction being fetched.
- pred_taken_o  out  1  predicted taken for if_pc_i (combinational).
- pred_target_o  out  XLEN  predicted target for if_pc_i (combinational).
- id_valid_i  in  1  ID holds a valid instruction.
- id_stall_i  in  1  ID is stalled; the instruction will be re-presented.
- id_Branch_i  in  1  ID instruction is a conditional branch.
- BranchTaken_i  in  1  resolved direction from branch determination.
- id_pc_i  in  XLEN  PC of the ID instruction.
- id_target_i  in  XLEN  resolved branch target (PC + B-imm).
- id_pred_taken_i  in  1  prediction carried down with the instruction.
- id_pred_target_i  in  XLEN  predicted target carried down with the instruction.
- flush_o  out  1  squash IF/ID (registered pulse).
- redirect_pc_o  out  XLEN  correct next PC; valid while flush_o = 1.
- branch_cnt_o  out  32  resolved-branch count (see Optional Feature).
- mispred_cnt_o  out  32  misprediction count (see Optional Feature).

Behaviour:
- Synchronous, active-high reset (rst_i) only; no asynchronous reset.
- Indexing:
  - IDX_W = log2(BHT_ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
- Per-entry state: valid bit, tag, target[XLEN-1:2] (bits [1:0] read back as 0), 2-bit counter.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken_o = hit && cnt[idx][1].
  - pred_target_o = hit ? stored target : if_pc_i + 4.
- Resolve event: id_valid_i && !id_stall_i && id_Branch_i && !flush_o. All four terms are required.
- On a resolve event, at the next clock edge:
  - Counter: saturating +1 if BranchTaken_i, saturating -1 otherwise; 2'b11 stays at 2'b11 on taken, 2'b00 stays at 2'b00 on not-taken.
  - If BranchTaken_i: write valid = 1, the tag and the target into the entry. Allocation may replace a different tag; the counter is then set to 2'b10 instead of being incremented.
  - If not taken and the tag differs: BTB entry unchanged, counter still decremented (aliasing is accepted).
- Mispredict condition: (id_pred_taken_i != BranchTaken_i) || (BranchTaken_i && id_pred_taken_i && id_pred_target_i != id_target_i).
- FSM, 2 states:
  - RUN → RECOVER on a resolve event with mispredict. In the RECOVER cycle: flush_o = 1 and redirect_pc_o = BranchTaken_i ? id_target_i : id_pc_i + 4 (value captured at the transition).
  - RECOVER → RUN unconditionally after 1 cycle.
  - In RECOVER, the ID input is wrong-path: no update, no counting, no new flush.
- Latency: mispredict is visible on flush_o 1 cycle after the resolving ID cycle.
- Simultaneous lookup and update to the same idx: lookup returns the pre-update value; there is no bypass.
- Non-branch or stalled ID cycles: no state change.
- Reset values:
  - All valid bits = 0 and all counters = INIT_CNT, taking effect in a single cycle.
  - flush_o = 0, redirect_pc_o = 0, FSM = RUN, both count outputs = 0.
- Reset asserted during RECOVER: flush_o drops to 0 at that edge.
- PC arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - branch_cnt_o increments on every resolve event.
  - mispred_cnt_o increments on every resolve event that mispredicts.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst_i.
- Undefined:
  - Counter registers are not instantiated.
  - Both ports are tied to 32'h0. The ports stay present.

Test Plan:
- Reset, then if_pc_i = 0x100 → pred_taken_o = 0, pred_target_o = 0x104, flush_o = 0.
- Cold taken branch: id_pc_i = 0x100, id_target_i = 0x180, BranchTaken_i = 1, id_pred_taken_i = 0.
  - Next cycle: flush_o = 1, redirect_pc_o = 0x180.
  - Then if_pc_i = 0x100 → pred_taken_o = 1 (cnt = 2'b10), pred_target_o = 0x180.
- Train the same branch taken 3 more times → cnt = 2'b11 (saturation).
  - 2 not-taken resolves → cnt = 2'b01 and pred_taken_o = 0.
  - The first not-taken resolve (predicted taken) flushes with redirect_pc_o = 0x104.
- Wrong-path squash: mispredict at cycle N → at N+1 present a resolving branch with mismatch → no second flush, table unchanged.
- Stall hold: id_stall_i = 1 for 3 cycles with a branch in ID → no update and no flush; release → exactly one update.
- Target mismatch and perf counters: BranchTaken_i = 1, id_pred_taken_i = 1, id_pred_target_i = 0x180, id_target_i = 0x200 → flush_o with redirect_pc_o = 0x200.
  - With BP_PERF_CNT_EN, after this sequence branch_cnt_o and mispred_cnt_o match a scoreboard.
  - Without the macro, both read 0.
